alu_arbiter: RTL and testbench

Shares one ALU instance between NUM_REQ requesters, e.g. the main pipeline's execute stage and a multi-cycle address/branch helper.
Each requester issues an operation via a valid/ready request handshake. A round-robin arbiter picks one requester and registers its operands. The ALU evaluates the op, and the registered result is returned on a per-requester valid/ready response channel.
Only one operation is in flight at a time.

---
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one 32-bit ALU between NUM_REQ requesters,
// one operation in flight at a time, with per-requester request/response handshakes.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [4*NUM_REQ-1:0]    req_op,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [31:0]             resp_out,
    output logic                    resp_zero,
    output logic [IDW-1:0]          resp_id,
    output logic                    busy
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state, state_nxt;
    logic [IDW-1:0]      last_grant;
    logic [IDW-1:0]      grant_id;
    logic [IDW-1:0]      cand;
    logic                grant_found;
    logic [3:0]          sel_op;
    logic [DATA_W-1:0]   sel_a, sel_b;
    logic [3:0]          op_p0;
    logic [DATA_W-1:0]   a_p0, b_p0;
    logic [IDW-1:0]      id_p0;

    function automatic logic [DATA_W-1:0] alu_eval(input logic [3:0] op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        case (op)
            4'b0000: alu_eval = a & b;
            4'b0001: alu_eval = a | b;
            4'b0010: alu_eval = a + b;
            4'b0110: alu_eval = a - b;
            4'b0111: alu_eval = {{(DATA_W-1){1'b0}}, (a < b)};
            4'b1100: alu_eval = ~(a | b);
            default: alu_eval = '0;
        endcase
    endfunction

    function automatic logic alu_zero(input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b);
        alu_zero = ((b - a) == '0);
    endfunction

    // Scan starts just past the previous winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_op = req_op[4*i +: 4];
                sel_a  = req_a[DATA_W*i +: DATA_W];
                sel_b  = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    assign req_ready = (state == IDLE && !reset && grant_found) ?
                       (NUM_REQ'(1) << grant_id) : '0;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_found) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_ready[id_p0]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= IDW'(NUM_REQ - 1);
            id_p0      <= '0;
            op_p0      <= '0;
            a_p0       <= '0;
            b_p0       <= '0;
            resp_valid <= '0;
            resp_out   <= '0;
            resp_zero  <= 1'b0;
            resp_id    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                // p0: operands of the granted requester captured
                IDLE: if (grant_found) begin
                    op_p0      <= sel_op;
                    a_p0       <= sel_a;
                    b_p0       <= sel_b;
                    id_p0      <= grant_id;
                    last_grant <= grant_id;
                end
                // p1: ALU result registered and presented to the owner
                EXEC: begin
                    resp_out   <= alu_eval(op_p0, a_p0, b_p0);
                    resp_zero  <= alu_zero(a_p0, b_p0);
                    resp_id    <= id_p0;
                    resp_valid <= NUM_REQ'(1) << id_p0;
                end
                RESP: if (resp_ready[id_p0]) resp_valid <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (NUM_REQ=2): op table plus round-robin,
// backpressure, operand-hold and mid-operation reset sequences.
module tb_alu_arbiter;

    localparam int NUM_REQ = 2;
    localparam int IDW     = 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [4*NUM_REQ-1:0]  req_op;
    logic [32*NUM_REQ-1:0] req_a, req_b;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;
    logic [31:0]           resp_out;
    logic                  resp_zero;
    logic [IDW-1:0]        resp_id;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic        zero;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_out(resp_out), .resp_zero(resp_zero),
        .resp_id(resp_id), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_op[4*id +: 4] = op;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
    endtask

    // Called one cycle after the reset edge, reset still high.
    task automatic chk_cleared(input string tag);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_resp_out"},   resp_out,        32'd0);
        chk({tag, "_resp_zero"},  32'(resp_zero),  32'd0);
        chk({tag, "_resp_id"},    32'(resp_id),    32'd0);
        chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
    endtask

    task automatic run_op(input vec_t v);
        logic [1:0] m;
        m = 2'b01 << v.id;
        set_req(v.id, v.op, v.a, v.b);
        req_valid = m;
        #1;
        chk("op_req_ready", 32'(req_ready), 32'(m));
        step();
        req_valid = '0;
        chk("op_exec_busy", 32'(busy), 32'd1);
        chk("op_exec_noresp", 32'(resp_valid), 32'd0);
        step();
        chk("op_resp_valid", 32'(resp_valid), 32'(m));
        chk("op_resp_out", resp_out, v.out);
        chk("op_resp_zero", 32'(resp_zero), 32'(v.zero));
        chk("op_resp_id", 32'(resp_id), 32'(v.id));
        resp_ready = m;
        step();
        resp_ready = '0;
        chk("op_done_valid", 32'(resp_valid), 32'd0);
        chk("op_done_busy", 32'(busy), 32'd0);
        chk("op_done_hold", resp_out, v.out);
    endtask

    initial begin
        int ngrant, nresp;
        int gq[$];
        logic [31:0] rr_exp[2];

        vecs[0] = '{0, 4'b0010, 32'd5,        32'd7,        32'd12,       1'b0};
        vecs[1] = '{1, 4'b0110, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0};
        vecs[2] = '{1, 4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
        vecs[3] = '{1, 4'b0111, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
        vecs[4] = '{1, 4'b0111, 32'd1,        32'd2,        32'd1,        1'b0};
        vecs[5] = '{1, 4'b1100, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[6] = '{1, 4'b1111, 32'd9,        32'd9,        32'd0,        1'b1};
        vecs[7] = '{1, 4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0};
        vecs[8] = '{1, 4'b0001, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0};
        vecs[9] = '{0, 4'b0010, 32'd5,        32'd5,        32'd10,       1'b1};

        reset = 1'b1;
        req_valid = '0; resp_ready = '0;
        req_op = '0; req_a = '0; req_b = '0;
        step();
        step();
        chk_cleared("reset");
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // Round robin with both requesters always valid and responses always taken.
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(0, 4'b0010, 32'd10, 32'd1);
        set_req(1, 4'b0110, 32'd20, 32'd2);
        rr_exp[0] = 32'd11;
        rr_exp[1] = 32'd18;
        req_valid = 2'b11;
        resp_ready = 2'b11;
        #1;
        ngrant = 0;
        nresp = 0;
        for (int c = 0; c < 40 && (ngrant < 4 || nresp < 4); c++) begin
            if (req_ready != 0 && ngrant < 4) begin
                chk("rr_grant", 32'(req_ready), 32'(2'b01 << (ngrant % 2)));
                gq.push_back(ngrant % 2);
                ngrant++;
            end
            if (resp_valid != 0 && gq.size() > 0) begin
                int eid;
                eid = gq.pop_front();
                chk("rr_resp_valid", 32'(resp_valid), 32'(2'b01 << eid));
                chk("rr_resp_id", 32'(resp_id), 32'(eid));
                chk("rr_resp_out", resp_out, rr_exp[eid]);
                nresp++;
            end
            step();
        end
        chk("rr_grant_count", 32'(ngrant), 32'd4);
        chk("rr_resp_count", 32'(nresp), 32'd4);
        req_valid = '0;
        resp_ready = '0;

        // Backpressure on requester 0 while requester 1 waits.
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(0, 4'b0000, 32'h0000F0F0, 32'h0000FF00);
        set_req(1, 4'b0001, 32'd1, 32'd2);
        req_valid = 2'b11;
        #1;
        chk("bp_first_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b10;
        step();
        resp_ready = 2'b10;
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_valid", 32'(resp_valid), 32'h1);
            chk("bp_hold_out", resp_out, 32'h0000F000);
            chk("bp_hold_zero", 32'(resp_zero), 32'd0);
            chk("bp_no_grant", 32'(req_ready), 32'd0);
            step();
        end
        resp_ready = 2'b01;
        step();
        resp_ready = 2'b00;
        chk("bp_released", 32'(resp_valid), 32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        step();
        chk("bp_r1_valid", 32'(resp_valid), 32'h2);
        chk("bp_r1_out", resp_out, 32'd3);
        chk("bp_r1_id", 32'(resp_id), 32'd1);
        resp_ready = 2'b10;
        step();
        resp_ready = '0;

        // Operand change after the grant edge.
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(0, 4'b0010, 32'd100, 32'd1);
        req_valid = 2'b01;
        step();
        req_valid = '0;
        set_req(0, 4'b0010, 32'd200, 32'd1);
        step();
        chk("opchg_out", resp_out, 32'd101);
        chk("opchg_valid", 32'(resp_valid), 32'h1);
        resp_ready = 2'b01;
        step();
        resp_ready = '0;

        // Reset while in EXEC (last_grant=0, so requester 1 wins here).
        set_req(0, 4'b0010, 32'd1, 32'd2);
        set_req(1, 4'b0010, 32'd3, 32'd4);
        req_valid = 2'b11;
        #1;
        chk("rst_exec_grant", 32'(req_ready), 32'h2);
        step();
        chk("rst_exec_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        chk_cleared("rst_exec");
        step();
        chk("rst_exec_no_resp", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_exec_regrant", 32'(req_ready), 32'h1);

        // Reset while in RESP.
        step();
        step();
        chk("rst_resp_valid", 32'(resp_valid), 32'h1);
        chk("rst_resp_out", resp_out, 32'd3);
        reset = 1'b1;
        step();
        chk_cleared("rst_resp");
        reset = 1'b0;
        #1;
        chk("rst_resp_regrant", 32'(req_ready), 32'h1);
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
